// File: rtl/fetch_seq_if.sv
// Fetch-side bus bundle: instruction memory request/ack plus the
// downstream instruction handoff and redirect inputs.
interface fetch_seq_if;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [DW-1:0] imem_rdata;
    logic          instr_valid;
    logic [DW-1:0] instr_out;
    logic [AW-1:0] instr_pc;
    logic          instr_take;
    logic          redirect;
    logic [AW-1:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr_out, instr_pc,
        input  imem_ack, imem_rdata, instr_take, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr_out, instr_pc,
        output imem_ack, imem_rdata, instr_take, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_seq.sv
// Single-outstanding instruction fetch sequencer: issues one memory request,
// holds the returned word for the consumer, and handles branch redirects.
module fetch_seq #(
    parameter logic [15:0] RESET_PC = 16'h02E1,
    parameter logic [15:0] PC_INC   = 16'd1
) (
    input  logic       clk,
    input  logic       nClear,
    fetch_seq_if.master bus
);
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t        state;
    logic [AW-1:0] pc;
    logic [AW-1:0] pend_pc;
    logic [DW-1:0] instr_q;
    logic [AW-1:0] instr_pc_q;
    logic          req_q;
    logic          valid_q;

    // The address only moves when the FSM leaves REQ/DROP, so it is stable
    // for the whole life of a request.
    assign bus.imem_addr   = pc;
    assign bus.imem_req    = req_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr_out   = instr_q;
    assign bus.instr_pc    = instr_pc_q;

    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            pend_pc    <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state <= REQ;
                    req_q <= 1'b1;
                end

                REQ: begin
                    if (bus.imem_ack && bus.redirect) begin
                        pc <= bus.redirect_pc;
                    end else if (bus.redirect) begin
                        pend_pc <= bus.redirect_pc;
                        state   <= DROP;
                    end else if (bus.imem_ack) begin
                        instr_q    <= bus.imem_rdata;
                        instr_pc_q <= pc;
                        pc         <= AW'(pc + PC_INC);
                        req_q      <= 1'b0;
                        valid_q    <= 1'b1;
                        state      <= HOLD;
                    end
                end

                // Wait out the stale request; the newest redirect target wins.
                DROP: begin
                    if (bus.imem_ack) begin
                        pc    <= bus.redirect ? bus.redirect_pc : pend_pc;
                        state <= REQ;
                    end else if (bus.redirect) begin
                        pend_pc <= bus.redirect_pc;
                    end
                end

                HOLD: begin
                    if (bus.redirect) begin
                        pc      <= bus.redirect_pc;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                        state   <= REQ;
                    end else if (bus.instr_take) begin
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                        state   <= REQ;
                    end
                end

                default: begin
                    state   <= IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_seq.sv
// Directed self-checking bench for fetch_seq.
module tb_fetch_seq;
    logic clk;
    logic nClear;
    logic use_fixed;
    logic [15:0] rdata_drv;

    int checks = 0;
    int errors = 0;

    fetch_seq_if ifc ();

    fetch_seq #(.RESET_PC(16'h02E1), .PC_INC(16'd1)) dut (
        .clk    (clk),
        .nClear (nClear),
        .bus    (ifc)
    );

    // Default memory content is the inverted address, so stale data is recognisable.
    assign ifc.imem_rdata = use_fixed ? rdata_drv : ~ifc.imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req"},   16'(ifc.imem_req),    16'h0000);
        check({tag, "_valid"}, 16'(ifc.instr_valid), 16'h0000);
        check({tag, "_out"},   ifc.instr_out,        16'h0000);
        check({tag, "_ipc"},   ifc.instr_pc,         16'h0000);
        check({tag, "_addr"},  ifc.imem_addr,        16'h02E1);
    endtask

    task automatic check_req(input string tag, input logic [15:0] addr);
        check({tag, "_req"},   16'(ifc.imem_req),    16'h0001);
        check({tag, "_addr"},  ifc.imem_addr,        addr);
        check({tag, "_valid"}, 16'(ifc.instr_valid), 16'h0000);
    endtask

    task automatic check_hold(input string tag, input logic [15:0] ipc, input logic [15:0] data);
        check({tag, "_valid"}, 16'(ifc.instr_valid), 16'h0001);
        check({tag, "_req"},   16'(ifc.imem_req),    16'h0000);
        check({tag, "_ipc"},   ifc.instr_pc,         ipc);
        check({tag, "_out"},   ifc.instr_out,        data);
    endtask

    initial begin
        nClear          = 1'b1;
        use_fixed       = 1'b0;
        rdata_drv       = 16'h0000;
        ifc.imem_ack    = 1'b1;
        ifc.instr_take  = 1'b1;
        ifc.redirect    = 1'b0;
        ifc.redirect_pc = 16'h0000;

        // Streaming: ack and take held high from reset release.
        #2 nClear = 1'b0;
        #1 check_reset("rst0");
        step();
        nClear = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            check_req("stream_req", 16'h02E1 + 16'(k));
            step();
            check_hold("stream_hold", 16'h02E1 + 16'(k), ~(16'h02E1 + 16'(k)));
            step();
        end

        // Ack delayed three cycles.
        ifc.imem_ack   = 1'b0;
        ifc.instr_take = 1'b0;
        nClear = 1'b0;
        #2 check_reset("rst1");
        step();
        nClear = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            check_req("slow_req", 16'h02E1);
            if (i == 3) begin
                ifc.imem_ack = 1'b1;
                use_fixed    = 1'b1;
                rdata_drv    = 16'h1234;
            end
            step();
        end
        ifc.imem_ack = 1'b0;
        check_hold("slow_hold", 16'h02E1, 16'h1234);

        // Redirect while the request is outstanding goes through DROP.
        ifc.instr_take = 1'b1;
        step();
        ifc.instr_take = 1'b0;
        check_req("pre_drop", 16'h02E2);
        ifc.redirect    = 1'b1;
        ifc.redirect_pc = 16'h1000;
        step();
        ifc.redirect = 1'b0;
        check_req("drop0", 16'h02E2);
        step();
        check_req("drop1", 16'h02E2);
        ifc.imem_ack = 1'b1;
        rdata_drv    = 16'hDEAD;
        step();
        ifc.imem_ack = 1'b0;
        check_req("after_drop", 16'h1000);
        check("drop_discard", ifc.instr_out, 16'h1234);

        // Latest redirect wins in DROP, including one coincident with the ack.
        ifc.redirect    = 1'b1;
        ifc.redirect_pc = 16'h2000;
        step();
        ifc.redirect_pc = 16'h3000;
        step();
        ifc.redirect_pc = 16'h4000;
        ifc.imem_ack    = 1'b1;
        step();
        ifc.redirect = 1'b0;
        check_req("latest_wins", 16'h4000);

        // Redirect beats take in HOLD.
        rdata_drv = 16'h0BEE;
        step();
        ifc.imem_ack = 1'b0;
        check_hold("hold_4000", 16'h4000, 16'h0BEE);
        ifc.redirect    = 1'b1;
        ifc.instr_take  = 1'b1;
        ifc.redirect_pc = 16'h0040;
        step();
        ifc.instr_take = 1'b0;
        check_req("flush", 16'h0040);

        // Redirect with simultaneous ack, then wrap past FFFF.
        ifc.redirect_pc = 16'hFFFF;
        ifc.imem_ack    = 1'b1;
        step();
        ifc.redirect = 1'b0;
        check_req("redir_ack", 16'hFFFF);
        rdata_drv = 16'h7777;
        step();
        check_hold("hold_ffff", 16'hFFFF, 16'h7777);
        rdata_drv = 16'h1111;
        step();
        check_hold("ack_ignored", 16'hFFFF, 16'h7777);
        ifc.imem_ack   = 1'b0;
        ifc.instr_take = 1'b1;
        step();
        ifc.instr_take = 1'b0;
        check_req("wrap", 16'h0000);

        // Asynchronous reset in the middle of DROP.
        ifc.redirect    = 1'b1;
        ifc.redirect_pc = 16'h5555;
        step();
        ifc.redirect = 1'b0;
        check_req("drop_rst", 16'h0000);
        #2 nClear = 1'b0;
        #1 check_reset("rst_async");
        #1 nClear = 1'b1;
        step();
        check_req("restart", 16'h02E1);
        ifc.imem_ack = 1'b1;
        rdata_drv    = 16'hABCD;
        step();
        ifc.imem_ack = 1'b0;
        check_hold("restart_hold", 16'h02E1, 16'hABCD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Parameter RESET_PC, default 16'h02E1, is the first fetch address after reset.
REQ-002 Parameter PC_INC, default 16'd1, is the sequential address step (word-addressed).
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 nClear  input  1  the reset, asynchronous and active-low; it clears all state immediately, independent of clk.
REQ-005 imem_req  output  1  instruction memory request.
REQ-006 imem_addr  output  16  fetch address; valid while imem_req=1.
REQ-007 imem_ack  input  1  memory completion; meaningful only while imem_req=1.
REQ-008 imem_rdata  input  16  instruction word; valid in the same cycle as imem_ack.
REQ-009 instr_valid  output  1  instr_out and instr_pc hold a fetched instruction.
REQ-010 instr_out  output  16  fetched instruction, fed to the downstream 16-bit instruction register.
REQ-011 instr_pc  output  16  address instr_out was fetched from.
REQ-012 instr_take  input  1  the consumer accepts instr_out this cycle; ignored unless instr_valid=1.
REQ-013 redirect  input  1  branch/jump; replaces the next fetch address.
REQ-014 redirect_pc  input  16  target address; sampled when redirect=1.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, DROP and HOLD; all outputs are registered or decoded from registered state only.
REQ-016 IDLE: imem_req=0, instr_valid=0; the FSM goes to REQ at the next edge unconditionally.
REQ-017 REQ: imem_req=1, imem_addr=pc; pc, imem_req and imem_addr stay stable until imem_ack=1 (no withdrawal).
REQ-018 REQ, ack=1, redirect=0: instr_out<=imem_rdata; instr_pc<=pc; pc<=pc+PC_INC (mod 2^16); go to HOLD.
REQ-019 REQ, ack=0, redirect=0: stay in REQ with no state change.
REQ-020 REQ, redirect=1, ack=1: discard imem_rdata; pc<=redirect_pc; instr_valid remains 0; go to REQ, so the new request is issued the next cycle.
REQ-021 REQ, redirect=1, ack=0: pend_pc<=redirect_pc; go to DROP.
REQ-022 DROP: imem_req=1 with the original imem_addr until ack; on ack discard the data, pc<=pend_pc, go to REQ; a redirect in DROP overwrites pend_pc (latest wins; a redirect in the same cycle as the ack uses the new redirect_pc).
REQ-023 HOLD: instr_valid=1, imem_req=0; instr_out and instr_pc are held constant.
REQ-024 HOLD, take=1, redirect=0: go to REQ; instr_valid is 0 in the next cycle.
REQ-025 HOLD, redirect=1: pc<=redirect_pc; go to REQ; instr_valid is 0 in the next cycle; redirect has priority over instr_take (the held instruction is flushed).
REQ-026 An imem_ack with imem_req=0 SHALL be ignored.
REQ-027 PC increment SHALL wrap 16'hFFFF+1 to 16'h0000 with no flag.
REQ-028 Best-case throughput, with ack in the first REQ cycle and take in the first HOLD cycle, SHALL be one instruction every 2 cycles.

Reset
REQ-029 While nClear=0: state=IDLE, pc=RESET_PC, pend_pc=16'h0000, instr_out=16'h0000, instr_pc=16'h0000, instr_valid=0, imem_req=0.
REQ-030 Reset asserted mid-request SHALL abandon the request with no pending ack tracked; after release the first imem_addr is RESET_PC.
REQ-031 The first rising edge after nClear rises SHALL move IDLE to REQ.

Verification
REQ-032 Reset release, ack held 1, take held 1 -> imem_addr 02E1, 02E2, 02E3 on alternating cycles; instr_pc matches each address; instr_valid toggles 0/1.
REQ-033 Ack delayed 3 cycles at 02E1 -> imem_req and imem_addr=02E1 are stable for 4 cycles; instr_valid rises the cycle after the ack; instr_out equals the rdata presented with the ack.
REQ-034 Redirect to 1000 while in REQ with ack withheld 2 cycles -> DROP entered; the old address is held until ack; the data is discarded with no instr_valid; the next imem_addr is 1000.
REQ-035 In HOLD, redirect=1 and take=1 together with redirect_pc=0040 -> instr_valid drops; the next imem_addr is 0040.
REQ-036 Redirect to FFFF, ack, take -> the next imem_addr is 0000.
REQ-037 nClear pulsed low mid-DROP, asynchronous to clk -> all outputs take their reset values immediately; after release, fetch restarts at 02E1.
